// File: rtl/fsm_job_initiator.sv
// Job initiator: queues job ids, issues them one at a time to a worker FSM and reports completion or watchdog abort.
// Define FSM_INIT_STATE_CHECK_EN to enable a sticky err_state flag for non-one-hot state vectors.
module fsm_job_initiator #(
  parameter int ID_W           = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [ID_W-1:0] req_id,
  output logic            req_ready,
  output logic            start,
  input  logic            done,
  output logic            busy,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic            rsp_timeout,
  output logic [7:0]      job_count,
  output logic            err_state
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] S_IDLE   = 4'b0001;
  localparam logic [3:0] S_ISSUE  = 4'b0010;
  localparam logic [3:0] S_WAIT   = 4'b0100;
  localparam logic [3:0] S_REPORT = 4'b1000;

  logic [3:0]       state_q, state_d;
  logic [ID_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ID_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic [7:0]       job_count_q, job_count_d;
  logic             push, pop, empty;
`ifdef FSM_INIT_STATE_CHECK_EN
  logic             err_q, err_d;
`endif

  // No full-bypass: a full queue refuses even while the head is being popped
  assign req_ready = (count_q != FULL_CNT);
  assign empty     = (count_q == '0);
  assign push      = req_valid && req_ready;

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    state_d       = state_q;
    timer_d       = timer_q;
    start_d       = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_timeout_d = rsp_timeout_q;
    job_count_d   = job_count_q;
    pop           = 1'b0;
`ifdef FSM_INIT_STATE_CHECK_EN
    err_d         = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_ISSUE;
          start_d = 1'b1;
        end
      end
      S_ISSUE: begin
        pop      = !empty;
        rsp_id_d = mem_q[rd_ptr_q];
        timer_d  = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // Completion wins over the watchdog when both land on the same cycle
        if (done) begin
          state_d       = S_REPORT;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b0;
        end else if (timer_q == TMR_LAST) begin
          state_d       = S_REPORT;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      S_REPORT: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          if (!rsp_timeout_q && job_count_q != 8'hFF) begin
            job_count_d = job_count_q + 8'd1;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
`ifdef FSM_INIT_STATE_CHECK_EN
        err_d       = 1'b1;
`endif
      end
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = req_id;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_timeout_q <= 1'b0;
      job_count_q   <= 8'd0;
    end else begin
      mem_q         <= mem_d;
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_timeout_q <= rsp_timeout_d;
      job_count_q   <= job_count_d;
    end
  end

`ifdef FSM_INIT_STATE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err_state = err_q;
`else
  assign err_state = 1'b0;
`endif

  assign start       = start_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_timeout = rsp_timeout_q;
  assign job_count   = job_count_q;

endmodule

// File: tb/tb_fsm_job_initiator.sv
// Self-checking bench for fsm_job_initiator: directed scenarios plus randomized jobs checked against
// a job-level reference model (FIFO order, latency = 2 + min(done delay, timeout), saturating count).
module tb_fsm_job_initiator;
  localparam int ID_W = 4;
  localparam int DEPTH = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic [ID_W-1:0] req_id = '0;
  logic            done = 1'b0;
  logic            rsp_ready = 1'b0;
  logic            req_ready, start, busy, rsp_valid, rsp_timeout, err_state;
  logic [ID_W-1:0] rsp_id;
  logic [7:0]      job_count;

  int checks = 0;
  int errors = 0;
  int worker_delay = 0;
  int exp_jobs = 0;

  fsm_job_initiator #(.ID_W(ID_W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_id(req_id), .req_ready(req_ready),
    .start(start), .done(done), .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_timeout(rsp_timeout), .job_count(job_count), .err_state(err_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Worker model: pulses done worker_delay cycles after it sees start (0 = never answers)
  initial begin : worker
    int k;
    forever begin
      @(posedge clk);
      #1;
      if (start === 1'b1 && worker_delay > 0) begin
        k = worker_delay;
        repeat (k) @(posedge clk);
        #1 done = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) step();
    checks++;
    if ({start, busy, rsp_valid, rsp_timeout, err_state, req_ready} !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b expected 000001", {start, busy, rsp_valid, rsp_timeout, err_state, req_ready});
    end
    checks++;
    if (rsp_id !== '0) begin errors++; $display("[TB] FAIL reset_rsp_id got %0d expected 0", rsp_id); end
    checks++;
    if (job_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_job_count got %0d expected 0", job_count); end
    rst_n = 1'b1;
    exp_jobs = 0;
    repeat (2) step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b expected 0", busy); end
  endtask

  task automatic test_single();
    int lat = -1;
    int starts = 0;
    logic [ID_W-1:0] got_id = '0;
    logic got_to = 1'b1;
    worker_delay = 2; rsp_ready = 1'b1;
    req_id = 4'd3; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (start === 1'b1) starts++;
      if (rsp_valid === 1'b1 && lat < 0) begin lat = c; got_id = rsp_id; got_to = rsp_timeout; end
      step();
    end
    exp_jobs++;
    checks++;
    if (lat != 2 + 2) begin errors++; $display("[TB] FAIL single_latency got %0d expected 4", lat); end
    checks++;
    if (got_id !== 4'd3) begin errors++; $display("[TB] FAIL single_id got %0d expected 3", got_id); end
    checks++;
    if (got_to !== 1'b0) begin errors++; $display("[TB] FAIL single_timeout got %b expected 0", got_to); end
    checks++;
    if (starts != 1) begin errors++; $display("[TB] FAIL single_starts got %0d expected 1", starts); end
    checks++;
    if (job_count !== 8'(exp_jobs)) begin errors++; $display("[TB] FAIL single_job_count got %0d expected %0d", job_count, exp_jobs); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int exp_ids[$];
    int got_ids[$];
    int got_to = 0;
    int n;
    bit seen_start = 0;
    bit check_next = 0;
    worker_delay = 1; rsp_ready = 1'b0;
    exp_ids = '{15, 0, 1, 2, 3, 4};
    req_id = 4'd15; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (n = 0; n < 20 && rsp_valid !== 1'b1; n++) step();
    checks++;
    if (n == 20) begin errors++; $display("[TB] FAIL b2b_blocker_report got timeout expected rsp_valid"); end
    for (int i = 0; i < DEPTH; i++) begin
      req_id = ID_W'(i); req_valid = 1'b1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept_%0d got %b expected 1", i, req_ready); end
      step();
    end
    req_id = 4'd4; req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full got %b expected 0", req_ready); end
    rsp_ready = 1'b1;
    for (n = 0; n < 200 && got_ids.size() < 6; n++) begin
      bit pushed;
      if (rsp_valid === 1'b1) begin got_ids.push_back(int'(rsp_id)); got_to += int'(rsp_timeout); end
      if (check_next) begin
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_after_pop got %b expected 1", req_ready); end
        check_next = 0;
      end
      if (start === 1'b1 && !seen_start) begin
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_at_pop got %b expected 0", req_ready); end
        seen_start = 1; check_next = 1;
      end
      pushed = (req_valid === 1'b1 && req_ready === 1'b1);
      step();
      if (pushed) req_valid = 1'b0;
    end
    rsp_ready = 1'b0; req_valid = 1'b0;
    checks++;
    if (got_ids.size() != 6) begin errors++; $display("[TB] FAIL b2b_report_count got %0d expected 6", got_ids.size()); end
    for (int i = 0; i < got_ids.size() && i < 6; i++) begin
      checks++;
      if (got_ids[i] != exp_ids[i]) begin errors++; $display("[TB] FAIL b2b_order_%0d got %0d expected %0d", i, got_ids[i], exp_ids[i]); end
    end
    exp_jobs += 6;
    checks++;
    if (got_to != 0 || job_count !== 8'(exp_jobs)) begin
      errors++; $display("[TB] FAIL b2b_job_count got %0d (timeouts %0d) expected %0d", job_count, got_to, exp_jobs);
    end
  endtask

  task automatic test_timeout();
    int lat = -1;
    logic [ID_W-1:0] got_id = '0;
    logic got_to = 1'b0;
    worker_delay = 0; rsp_ready = 1'b1;
    req_id = 4'd9; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid === 1'b1 && lat < 0) begin lat = c; got_id = rsp_id; got_to = rsp_timeout; end
      step();
    end
    checks++;
    if (lat != 2 + TO) begin errors++; $display("[TB] FAIL timeout_latency got %0d expected %0d", lat, 2 + TO); end
    checks++;
    if (got_to !== 1'b1 || got_id !== 4'd9) begin errors++; $display("[TB] FAIL timeout_report got to=%b id=%0d expected to=1 id=9", got_to, got_id); end
    checks++;
    if (job_count !== 8'(exp_jobs)) begin errors++; $display("[TB] FAIL timeout_job_count got %0d expected %0d", job_count, exp_jobs); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    worker_delay = 3; rsp_ready = 1'b0;
    req_id = 4'd6; req_valid = 1'b1;
    step();
    req_id = 4'd7;
    step();
    req_valid = 1'b0;
    for (n = 0; n < 30 && rsp_valid !== 1'b1; n++) step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 4'd6 || rsp_timeout !== 1'b0 || start !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_hold_%0d got valid=%b id=%0d to=%b start=%b expected 1/6/0/0", i, rsp_valid, rsp_id, rsp_timeout, start);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    for (n = 0; n < 30 && rsp_valid !== 1'b1; n++) step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 4'd7) begin errors++; $display("[TB] FAIL stall_second got valid=%b id=%0d expected 1/7", rsp_valid, rsp_id); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_jobs += 2;
    checks++;
    if (job_count !== 8'(exp_jobs)) begin errors++; $display("[TB] FAIL stall_job_count got %0d expected %0d", job_count, exp_jobs); end
    repeat (3) step();
  endtask

  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      int k, s, c, starts, exp_lat;
      bit exp_to;
      logic [ID_W-1:0] id;
      id = ID_W'($urandom_range(0, 15));
      k = (it == 0) ? TO : (it == 1) ? TO + 1 : int'($urandom_range(0, TO + 3));
      s = int'($urandom_range(0, 4));
      exp_to = (k == 0 || k > TO);
      exp_lat = 2 + (exp_to ? TO : k);
      worker_delay = k; rsp_ready = 1'b0;
      req_id = id; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      starts = 0;
      for (c = 0; c < 60; c++) begin
        if (rsp_valid === 1'b1) break;
        if (start === 1'b1) starts++;
        step();
      end
      checks++;
      if (c != exp_lat || starts != 1) begin errors++; $display("[TB] FAIL rand_latency_%0d got lat=%0d starts=%0d expected lat=%0d starts=1 (k=%0d)", it, c, starts, exp_lat, k); end
      checks++;
      if (rsp_id !== id || rsp_timeout !== exp_to) begin errors++; $display("[TB] FAIL rand_report_%0d got id=%0d to=%b expected id=%0d to=%b", it, rsp_id, rsp_timeout, id, exp_to); end
      repeat (s) step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== id) begin errors++; $display("[TB] FAIL rand_hold_%0d got valid=%b id=%0d expected 1/%0d", it, rsp_valid, rsp_id, id); end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      if (!exp_to && exp_jobs < 255) exp_jobs++;
      checks++;
      if (rsp_valid !== 1'b0 || job_count !== 8'(exp_jobs)) begin errors++; $display("[TB] FAIL rand_count_%0d got valid=%b count=%0d expected 0/%0d", it, rsp_valid, job_count, exp_jobs); end
      repeat (5) step();
    end
  endtask

  task automatic test_reset_midjob();
    bit bad = 0;
    worker_delay = 0; rsp_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      req_id = ID_W'(i); req_valid = 1'b1;
      step();
    end
    req_valid = 1'b0;
    repeat (2) step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midjob_busy got %b expected 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({start, busy, rsp_valid, rsp_timeout, req_ready} !== 5'b00001 || rsp_id !== '0 || job_count !== 8'd0) begin
      errors++; $display("[TB] FAIL midjob_reset_values got flags=%b id=%0d count=%0d expected 00001/0/0", {start, busy, rsp_valid, rsp_timeout, req_ready}, rsp_id, job_count);
    end
    step();
    rst_n = 1'b1;
    exp_jobs = 0;
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid !== 1'b0 || start !== 1'b0 || busy !== 1'b0) bad = 1;
      step();
    end
    checks++;
    if (bad) begin errors++; $display("[TB] FAIL midjob_queue_dropped got activity expected idle"); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midjob_ready got %b expected 1", req_ready); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_saturation();
    int hs = 0;
    int n;
    worker_delay = 1; rsp_ready = 1'b1; req_valid = 1'b1;
    for (n = 0; n < 4000 && hs < 260; n++) begin
      req_id = ID_W'(n);
      if (rsp_valid === 1'b1) hs++;
      step();
    end
    req_valid = 1'b0;
    checks++;
    if (hs != 260) begin errors++; $display("[TB] FAIL sat_handshakes got %0d expected 260", hs); end
    for (int i = 0; i < hs; i++) if (exp_jobs < 255) exp_jobs++;
    repeat (40) step();
    checks++;
    if (job_count !== 8'(exp_jobs)) begin errors++; $display("[TB] FAIL sat_job_count got %0d expected %0d", job_count, exp_jobs); end
    rsp_ready = 1'b0;
  endtask

`ifdef FSM_INIT_STATE_CHECK_EN
  task automatic test_illegal_state();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    force dut.state_q = 4'b0011;
    #2 release dut.state_q;
    step();
    checks++;
    if (err_state !== 1'b1 || dut.state_q !== 4'b0001) begin errors++; $display("[TB] FAIL illegal_recover got err=%b state=%b expected 1/0001", err_state, dut.state_q); end
    repeat (3) step();
    checks++;
    if (err_state !== 1'b1) begin errors++; $display("[TB] FAIL illegal_sticky got %b expected 1", err_state); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (err_state !== 1'b0) begin errors++; $display("[TB] FAIL illegal_reset_clear got %b expected 0", err_state); end
    step();
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    $display("[TB] starting fsm_job_initiator bench");
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_stall();
    test_random(20);
    test_reset_midjob();
    test_saturation();
`ifdef FSM_INIT_STATE_CHECK_EN
    test_illegal_state();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("[TB] FAIL watchdog got no completion expected bench end");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_job_initiator.md
FSM_JOB_INITIATOR -- requirements
Module: fsm_job_initiator

Interface
REQ-001 SHALL have parameter ID_W, default 4, width of job identifier.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, job queue entries, power of two and at least 2.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum WAIT cycles before abort, at least 4.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1, job request offered.
REQ-007 SHALL have port req_id, input, ID_W, identifier of the offered job.
REQ-008 SHALL have port req_ready, output, 1, queue can accept a job.
REQ-009 SHALL have port start, output, 1, one-cycle start pulse to worker FSM.
REQ-010 SHALL have port done, input, 1, worker completion level.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-012 SHALL have port rsp_valid, output, 1, completion report valid.
REQ-013 SHALL have port rsp_ready, input, 1, report consumer ready.
REQ-014 SHALL have port rsp_id, output, ID_W, identifier of the reported job.
REQ-015 SHALL have port rsp_timeout, output, 1, reported job aborted by watchdog.
REQ-016 SHALL have port job_count, output, 8, successful completions, saturating.
REQ-017 SHALL have port err_state, output, 1, sticky illegal-state flag (see Configuration).

Function
REQ-018 SHALL buffer jobs in a FIFO_DEPTH-entry FIFO: push on req_valid && req_ready; req_ready = !full with no full-bypass; a push into an empty queue is not dispatched before the following cycle.
REQ-019 SHALL apply a simultaneous push and pop without loss or duplication; occupancy is unchanged.
REQ-020 SHALL encode states one-hot, 4 bits: IDLE, ISSUE, WAIT, REPORT.
REQ-021 SHALL transition IDLE->ISSUE when the queue is non-empty; otherwise hold IDLE.
REQ-022 SHALL in ISSUE assert start for exactly one cycle, pop the queue head into rsp_id, clear the timer, and go to WAIT.
REQ-023 SHALL in WAIT increment the timer each cycle; done high -> REPORT with rsp_timeout=0; else timer == TIMEOUT_CYCLES-1 -> REPORT with rsp_timeout=1; done takes priority on the same cycle.
REQ-024 SHALL ignore done outside WAIT.
REQ-025 SHALL in REPORT hold rsp_valid=1 with stable rsp_id and rsp_timeout until rsp_ready; on handshake go to IDLE.
REQ-026 SHALL increment job_count by 1 on each handshake with rsp_timeout=0, saturating at 255.
REQ-027 SHALL give a latency of 4 cycles from the first non-empty queue cycle to rsp_valid for a worker asserting done 2 cycles after start (IDLE, ISSUE, WAIT, REPORT).
REQ-028 SHALL register every output except req_ready.

Reset
REQ-029 SHALL on rst_n low force: state IDLE, queue empty, timer 0, start=0, busy=0, rsp_valid=0, rsp_id=0, rsp_timeout=0, job_count=0, err_state=0; req_ready=1 once state is idle and the queue empty.
REQ-030 SHALL, if reset is asserted mid-job, drop the job without a report and discard queued jobs.

Configuration
REQ-031 SHALL with FSM_INIT_STATE_CHECK_EN defined detect any state vector that is not one-hot, set err_state (sticky until reset), and return to IDLE next cycle, dropping the in-flight job.
REQ-032 SHALL without FSM_INIT_STATE_CHECK_EN tie err_state to 0; an illegal state still recovers to IDLE via the default branch.

Verification
REQ-033 SHALL cover: push id=3, worker done 2 cycles after start, rsp_ready=1 -> one start pulse, rsp_valid 4 cycles after push, rsp_id=3, rsp_timeout=0, job_count=1.
REQ-034 SHALL cover: push 5 jobs back-to-back, no dispatch possible -> req_ready=0 after 4 accepted; jobs report in order 0..3 and the 5th is accepted after the first pop.
REQ-035 SHALL cover: worker never asserts done, TIMEOUT_CYCLES=16 -> rsp_timeout=1 after 16 WAIT cycles and job_count unchanged.
REQ-036 SHALL cover: rsp_ready low for 5 cycles in REPORT -> rsp_valid and rsp_id held stable, no new start until handshake.
REQ-037 SHALL cover: rst_n low during WAIT with 2 jobs queued -> all outputs at reset values, no rsp_valid, queue empty afterwards.
REQ-038 SHALL cover: with the macro defined, force state=4'b0011 -> err_state=1 next cycle, state IDLE, err_state held until reset.
